// File: rtl/row_sched_pkg.sv
// Shared types and constants for the row ping-pong scheduler.
package row_sched_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } bank_state_t;

    localparam int                 STATS_W   = 16;
    localparam logic [STATS_W-1:0] STATS_MAX = {STATS_W{1'b1}};

endpackage

// File: rtl/row_bank_fsm.sv
// Per-bank lifecycle: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY.
module row_bank_fsm
    import row_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        wr_fire,
    input  logic        wr_last,
    input  logic        rd_fire,
    input  logic        rd_last,
    output bank_state_t state
);

    bank_state_t state_q, state_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (clear) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (wr_fire)            state_d = wr_last ? ST_FULL : ST_FILL;
                ST_FILL:  if (wr_fire && wr_last) state_d = ST_FULL;
                ST_FULL:  if (rd_fire)            state_d = rd_last ? ST_EMPTY : ST_DRAIN;
                ST_DRAIN: if (rd_fire && rd_last) state_d = ST_EMPTY;
                default:                          state_d = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/row_pingpong_sched.sv
// Ping-pong scheduler owning fill/drain addressing for two row banks.
// Optional statistics outputs are enabled with `define ROW_SCHED_STATS_EN.
module row_pingpong_sched
    import row_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [1:0]            bank_we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [1:0]            bank_rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] bank_dout0,
    input  logic [DATA_WIDTH-1:0] bank_dout1,
    output logic [1:0]            bank_full
`ifdef ROW_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0]    rows_done,
    output logic [STATS_W-1:0]    stall_cycles
`endif
);

    bank_state_t           bank_state [2];
    logic                  wsel_q, wsel_d, rsel_q, rsel_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                  wr_fire, rd_fire, wr_last, rd_last;

    // Handshake decode works off registered bank state only, so a freed bank opens next cycle.
    assign in_ready  = (bank_state[wsel_q] == ST_EMPTY) || (bank_state[wsel_q] == ST_FILL);
    assign out_valid = (bank_state[rsel_q] == ST_FULL)  || (bank_state[rsel_q] == ST_DRAIN);
    assign wr_fire   = in_valid  && in_ready  && !clear;
    assign rd_fire   = out_valid && out_ready && !clear;
    assign wr_last   = (wr_cnt_q == {ADDR_WIDTH{1'b1}});
    assign rd_last   = (rd_cnt_q == {ADDR_WIDTH{1'b1}});

    for (genvar i = 0; i < 2; i++) begin : g_bank
        row_bank_fsm u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear),
            .wr_fire (wr_fire && (wsel_q == 1'(i))),
            .wr_last (wr_last),
            .rd_fire (rd_fire && (rsel_q == 1'(i))),
            .rd_last (rd_last),
            .state   (bank_state[i])
        );
        assign bank_full[i] = (bank_state[i] == ST_FULL) || (bank_state[i] == ST_DRAIN);
    end

    always_comb begin
        bank_we    = '0;
        bank_rd_en = '0;
        if (wr_fire) bank_we[wsel_q]    = 1'b1;
        if (rd_fire) bank_rd_en[rsel_q] = 1'b1;
    end

    assign wr_addr  = wr_cnt_q;
    assign wr_data  = in_data;
    assign rd_addr  = rd_cnt_q;
    assign out_data = out_valid ? (rsel_q ? bank_dout1 : bank_dout0) : '0;
    assign out_last = rd_fire && rd_last;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wsel_d   = wsel_q;
        rsel_d   = rsel_q;
        if (clear) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            wsel_d   = 1'b0;
            rsel_d   = 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_last) wsel_d = ~wsel_q;
            end
            if (rd_fire) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_last) rsel_d = ~rsel_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
        end
    end

`ifdef ROW_SCHED_STATS_EN
    logic [STATS_W-1:0] rows_done_q, rows_done_d, stall_q, stall_d;

    always_comb begin
        rows_done_d = rows_done_q;
        stall_d     = stall_q;
        if (clear) begin
            rows_done_d = '0;
            stall_d     = '0;
        end else begin
            if (out_last && (rows_done_q != STATS_MAX))         rows_done_d = rows_done_q + 1'b1;
            if (in_valid && !in_ready && (stall_q != STATS_MAX)) stall_d     = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_done_q <= '0;
            stall_q     <= '0;
        end else begin
            rows_done_q <= rows_done_d;
            stall_q     <= stall_d;
        end
    end

    assign rows_done    = rows_done_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_row_pingpong_sched.sv
// Self-checking bench for row_pingpong_sched: phase table, hand sequences, random traffic vs row-level model.
module tb_row_pingpong_sched;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_last;
    logic [DW-1:0] out_data, wr_data, bank_dout0, bank_dout1;
    logic [1:0]    bank_we, bank_rd_en, bank_full;
    logic [AW-1:0] wr_addr, rd_addr;
`ifdef ROW_SCHED_STATS_EN
    logic [15:0]   rows_done, stall_cycles;
`endif

    row_pingpong_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .bank_we      (bank_we),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .bank_rd_en   (bank_rd_en),
        .rd_addr      (rd_addr),
        .bank_dout0   (bank_dout0),
        .bank_dout1   (bank_dout1),
        .bank_full    (bank_full)
`ifdef ROW_SCHED_STATS_EN
        ,
        .rows_done    (rows_done),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Plain storage banks with asynchronous read.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    always @(posedge clk) begin
        if (bank_we[0]) mem0[wr_addr] <= wr_data;
        if (bank_we[1]) mem1[wr_addr] <= wr_data;
    end
    assign bank_dout0 = mem0[rd_addr];
    assign bank_dout1 = mem1[rd_addr];

    // Row-level model: total words written/read since reset, plus FIFO of written words.
    int            wr_total, rd_total, m_rows, m_stall, lasts_seen;
    logic [DW-1:0] q [$];
    int            n_checks = 0;
    int            n_bad = 0;
    logic [DW-1:0] data_seq = 32'h100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wr_total = 0;
        rd_total = 0;
        m_rows   = 0;
        m_stall  = 0;
        q.delete();
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic orr, input logic clr);
        int            complete;
        logic          e_ir, e_ov, wf, rf, e_last;
        logic [1:0]    e_we, e_re, e_bf;
        logic [DW-1:0] e_od;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
        clear     = clr;
        #1;
        // A bank is busy while it holds a complete row not yet fully read.
        complete = wr_total / DEPTH - rd_total / DEPTH;
        e_ir   = (complete < 2);
        e_ov   = (complete >= 1);
        wf     = iv && e_ir && !clr;
        rf     = orr && e_ov && !clr;
        e_we   = wf ? (2'b01 << ((wr_total / DEPTH) % 2)) : 2'b00;
        e_re   = rf ? (2'b01 << ((rd_total / DEPTH) % 2)) : 2'b00;
        e_last = rf && ((rd_total % DEPTH) == DEPTH - 1);
        e_od   = e_ov ? q[0] : '0;
        e_bf   = 2'b00;
        for (int r = rd_total / DEPTH; r < wr_total / DEPTH; r++) e_bf[r % 2] = 1'b1;
        check("in_ready",   in_ready,   e_ir);
        check("out_valid",  out_valid,  e_ov);
        check("bank_we",    bank_we,    e_we);
        check("bank_rd_en", bank_rd_en, e_re);
        check("wr_addr",    wr_addr,    wr_total % DEPTH);
        check("rd_addr",    rd_addr,    rd_total % DEPTH);
        check("wr_data",    wr_data,    d);
        check("out_data",   out_data,   e_od);
        check("out_last",   out_last,   e_last);
        check("bank_full",  bank_full,  e_bf);
`ifdef ROW_SCHED_STATS_EN
        check("rows_done",    rows_done,    m_rows);
        check("stall_cycles", stall_cycles, m_stall);
`endif
        if (out_last) lasts_seen++;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            if (wf) begin
                q.push_back(d);
                wr_total++;
            end
            if (rf) begin
                void'(q.pop_front());
                rd_total++;
            end
            if (e_last && m_rows < 16'hFFFF)    m_rows++;
            if (iv && !e_ir && m_stall < 16'hFFFF) m_stall++;
        end
    endtask

    typedef struct {
        int         n;
        logic       iv;
        logic       orr;
        logic       clr;
        logic       e_ir;
        logic       e_ov;
        logic [1:0] e_bf;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01};  // fill bank 0, stalled consumer
        tbl[1] = '{16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11};  // fill bank 1 -> both full
        tbl[2] = '{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11};  // one read keeps in_ready low
        tbl[3] = '{15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10};  // 16th read frees bank 0
        tbl[4] = '{16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};  // drain bank 1
        tbl[5] = '{ 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};  // partial row in bank 0
        tbl[6] = '{ 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};  // clear discards it

        model_reset();
        lasts_seen = 0;
        #2;
        check("rst_in_ready",  in_ready,   1'b1);
        check("rst_out_valid", out_valid,  1'b0);
        check("rst_bank_full", bank_full,  2'b00);
        check("rst_bank_we",   bank_we,    2'b00);
        check("rst_rd_en",     bank_rd_en, 2'b00);
        check("rst_out_data",  out_data,   '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int p = 0; p < 7; p++) begin
            for (int c = 0; c < tbl[p].n; c++) begin
                step(tbl[p].iv, data_seq, tbl[p].orr, tbl[p].clr);
                data_seq++;
            end
            #1;
            check($sformatf("phase%0d_in_ready", p),  in_ready,  tbl[p].e_ir);
            check($sformatf("phase%0d_out_valid", p), out_valid, tbl[p].e_ov);
            check($sformatf("phase%0d_bank_full", p), bank_full, tbl[p].e_bf);
        end

        // After clear the next row starts at bank 0 address 0.
        step(1'b1, 32'hCAFE_0000, 1'b0, 1'b0);
        #1;
        check("post_clear_mem0_0", mem0[0], 32'hCAFE_0000);

        // Continuous streaming of 48 words; expect three row ends.
        step(1'b0, '0, 1'b0, 1'b1);
        lasts_seen = 0;
        data_seq   = 32'h200;
        for (int c = 0; c < 64; c++) begin
            step(c < 48, data_seq, 1'b1, 1'b0);
            if (c < 48) data_seq++;
        end
        check("stream_lasts", lasts_seen, 3);
        check("stream_reads", rd_total, 48);

        // Random traffic with occasional clears.
        for (int c = 0; c < 800; c++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) == 0));
        end

        // Asynchronous reset mid-drain.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int c = 0; c < DEPTH; c++) step(1'b1, $urandom, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++)     step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  in_ready,   1'b1);
        check("arst_out_valid", out_valid,  1'b0);
        check("arst_bank_full", bank_full,  2'b00);
        check("arst_rd_en",     bank_rd_en, 2'b00);
        check("arst_out_last",  out_last,   1'b0);
        check("arst_out_data",  out_data,   '0);
        check("arst_rd_addr",   rd_addr,    '0);
`ifdef ROW_SCHED_STATS_EN
        check("arst_rows_done", rows_done,    '0);
        check("arst_stall",     stall_cycles, '0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) step(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
